// File: rtl/video_fill_pkg.sv
// Shared constants and types for the rectangle-fill engine:
// register map, ctrl/status bit positions, FSM states and the clip helper.
package video_fill_pkg;

  localparam logic [2:0] REG_X0    = 3'd0;
  localparam logic [2:0] REG_Y0    = 3'd1;
  localparam logic [2:0] REG_W     = 3'd2;
  localparam logic [2:0] REG_H     = 3'd3;
  localparam logic [2:0] REG_COLOR = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;
  localparam logic [2:0] REG_CNT   = 3'd6;
  localparam logic [2:0] REG_ZERO  = 3'd7;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } fill_state_t;

  // Compare before subtracting so an origin past the edge never wraps.
  function automatic logic [10:0] clip_len(input logic [10:0] origin,
                                           input logic [10:0] len,
                                           input logic [10:0] limit);
    logic [10:0] room;
    room = 11'd0;
    if (origin >= limit) begin
      clip_len = 11'd0;
    end else begin
      room     = limit - origin;
      clip_len = (len < room) ? len : room;
    end
  endfunction

endpackage

// File: rtl/video_fill_ctrl_addr_gen.sv
// Column/row walker for the fill engine: steps cur_addr across a clipped
// rectangle one pixel per enabled cycle, jumping by the row stride at row ends.
module fill_addr_gen
  import video_fill_pkg::*;
#(
  parameter int HMAX = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [19:0] i_base,
  input  logic [10:0] i_cw,
  input  logic [10:0] i_ch,
  output logic [19:0] o_cur_addr,
  output logic        o_last
);

  localparam logic [19:0] STRIDE = 20'(HMAX);

  logic [10:0] r_col;
  logic [10:0] r_row;
  logic [19:0] r_row_base;
  logic [19:0] r_cur_addr;
  logic        w_more_cols;
  logic        w_more_rows;

  assign w_more_cols = (r_col < (i_cw - 11'd1));
  assign w_more_rows = (r_row < (i_ch - 11'd1));
  assign o_last      = !w_more_cols && !w_more_rows;
  assign o_cur_addr  = r_cur_addr;

  // Load the rectangle origin, then advance one pixel per granted step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col      <= 11'd0;
      r_row      <= 11'd0;
      r_row_base <= 20'd0;
      r_cur_addr <= 20'd0;
    end else if (i_load) begin
      r_col      <= 11'd0;
      r_row      <= 11'd0;
      r_row_base <= i_base;
      r_cur_addr <= i_base;
    end else if (i_step) begin
      if (w_more_cols) begin
        r_col      <= r_col + 11'd1;
        r_cur_addr <= r_cur_addr + 20'd1;
      end else if (w_more_rows) begin
        r_col      <= 11'd0;
        r_row      <= r_row + 11'd1;
        r_row_base <= r_row_base + STRIDE;
        r_cur_addr <= r_row_base + STRIDE;
      end else begin
        r_col      <= r_col;
      end
    end else begin
      r_col      <= r_col;
    end
  end

endmodule

// File: rtl/video_fill_ctrl.sv
// Rectangle-fill engine and frame-buffer write arbiter. CPU writes always win
// the frame-buffer port; the fill sequencer paints one pixel per free cycle.
module video_fill_ctrl
  import video_fill_pkg::*;
#(
  parameter int HMAX = 640,
  parameter int VMAX = 480,
  parameter int DW   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        write,
  input  logic [13:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        cpu_fb_cs,
  input  logic        cpu_fb_wr,
  input  logic [19:0] cpu_fb_addr,
  input  logic [31:0] cpu_fb_wr_data,
  output logic        fb_cs,
  output logic        fb_wr,
  output logic [19:0] fb_addr,
  output logic [31:0] fb_wr_data,
  output logic        busy
);

  fill_state_t r_state;
  fill_state_t w_next_state;

  logic [10:0]   r_x0;
  logic [10:0]   r_y0;
  logic [10:0]   r_w;
  logic [10:0]   r_h;
  logic [DW-1:0] r_color;
  logic          r_done;
  logic          r_aborted;
  logic [19:0]   r_pix_cnt;

  logic        w_reg_wr;
  logic        w_start;
  logic        w_abort;
  logic        w_cpu_wr;
  logic        w_grant;
  logic        w_busy;
  logic [10:0] w_cw;
  logic [10:0] w_ch;
  logic        w_empty;
  logic [19:0] w_base;
  logic [19:0] w_cur_addr;
  logic        w_last;
  logic        w_load;
  logic        w_unused;

  assign w_unused = ^{wr_data[31:11], addr[13:3]};

  assign w_reg_wr = cs & write;
  assign w_start  = w_reg_wr && (addr[2:0] == REG_CTRL) && wr_data[CTRL_START];
  assign w_abort  = w_reg_wr && (addr[2:0] == REG_CTRL) && wr_data[CTRL_ABORT];
  assign w_cpu_wr = cpu_fb_cs & cpu_fb_wr;
  assign w_busy   = (r_state != IDLE);
  assign busy     = w_busy;

  // Geometry registers are frozen while busy, so the clip can be live logic.
  assign w_cw    = clip_len(r_x0, r_w, 11'(HMAX));
  assign w_ch    = clip_len(r_y0, r_h, 11'(VMAX));
  assign w_empty = (w_cw == 11'd0) || (w_ch == 11'd0);
  assign w_base  = 20'(r_y0) * 20'(HMAX) + 20'(r_x0);
  assign w_load  = (r_state == SETUP);

  fill_addr_gen #(
    .HMAX(HMAX)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_step    (w_grant),
    .i_base    (w_base),
    .i_cw      (w_cw),
    .i_ch      (w_ch),
    .o_cur_addr(w_cur_addr),
    .o_last    (w_last)
  );

  // Frame-buffer port arbitration: CPU write, else engine in RUN, else CPU pass-through.
  always_comb begin
    fb_cs      = cpu_fb_cs;
    fb_wr      = cpu_fb_wr;
    fb_addr    = cpu_fb_addr;
    fb_wr_data = cpu_fb_wr_data;
    w_grant    = 1'b0;
    if (!w_cpu_wr && (r_state == RUN)) begin
      fb_cs      = 1'b1;
      fb_wr      = 1'b1;
      fb_addr    = w_cur_addr;
      fb_wr_data = 32'(r_color);
      w_grant    = 1'b1;
    end else begin
      w_grant    = 1'b0;
    end
  end

  // Fill sequencer next state; an abort overrides every other transition.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_next_state = SETUP;
        else         w_next_state = IDLE;
      end
      SETUP: begin
        if (w_empty) w_next_state = IDLE;
        else         w_next_state = RUN;
      end
      RUN: begin
        if (w_grant && w_last) w_next_state = IDLE;
        else                   w_next_state = RUN;
      end
      default: w_next_state = IDLE;
    endcase
    if (w_abort) w_next_state = IDLE;
    else         w_next_state = w_next_state;
  end

  // Fill sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Register file, status flags and pixel counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x0      <= 11'd0;
      r_y0      <= 11'd0;
      r_w       <= 11'd0;
      r_h       <= 11'd0;
      r_color   <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_pix_cnt <= 20'd0;
    end else begin
      if (w_reg_wr && !w_busy) begin
        case (addr[2:0])
          REG_X0:    r_x0    <= wr_data[10:0];
          REG_Y0:    r_y0    <= wr_data[10:0];
          REG_W:     r_w     <= wr_data[10:0];
          REG_H:     r_h     <= wr_data[10:0];
          REG_COLOR: r_color <= wr_data[DW-1:0];
          default:   r_x0    <= r_x0;
        endcase
      end
      if ((r_state == IDLE) && w_start && !w_abort) begin
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
        r_pix_cnt <= 20'd0;
      end
      if (w_grant) r_pix_cnt <= r_pix_cnt + 20'd1;
      if ((r_state == SETUP) && w_empty && !w_abort) r_done <= 1'b1;
      if (w_grant && w_last && !w_abort) r_done <= 1'b1;
      if (w_abort) r_aborted <= 1'b1;
    end
  end

  // Register readback mux.
  always_comb begin
    rd_data = 32'd0;
    case (addr[2:0])
      REG_X0:    rd_data = {21'd0, r_x0};
      REG_Y0:    rd_data = {21'd0, r_y0};
      REG_W:     rd_data = {21'd0, r_w};
      REG_H:     rd_data = {21'd0, r_h};
      REG_COLOR: rd_data = 32'(r_color);
      REG_CTRL:  rd_data = {29'd0, r_aborted, r_done, w_busy};
      REG_CNT:   rd_data = {12'd0, r_pix_cnt};
      default:   rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_video_fill_ctrl.sv
// Scoreboard bench for video_fill_ctrl: expected frame-buffer writes (address,
// data, cycle) are queued when a fill is started and checked as they appear.
module tb_video_fill_ctrl;
  import video_fill_pkg::*;

  localparam int HMAX = 640;
  localparam int VMAX = 480;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        write = 1'b0;
  logic [13:0] addr = 14'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        cpu_fb_cs = 1'b0;
  logic        cpu_fb_wr = 1'b0;
  logic [19:0] cpu_fb_addr = 20'd0;
  logic [31:0] cpu_fb_wr_data = 32'd0;
  logic        fb_cs;
  logic        fb_wr;
  logic [19:0] fb_addr;
  logic [31:0] fb_wr_data;
  logic        busy;

  video_fill_ctrl #(.HMAX(HMAX), .VMAX(VMAX), .DW(9)) dut (
    .clk(clk), .reset(reset), .cs(cs), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data),
    .cpu_fb_cs(cpu_fb_cs), .cpu_fb_wr(cpu_fb_wr), .cpu_fb_addr(cpu_fb_addr),
    .cpu_fb_wr_data(cpu_fb_wr_data),
    .fb_cs(fb_cs), .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_wr_data(fb_wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    logic [19:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every frame-buffer write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && fb_cs && fb_wr) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_write", {12'd0, fb_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check_eq("sb_addr", {12'd0, fb_addr}, {12'd0, mon_e.a});
        check_eq("sb_data", fb_wr_data, mon_e.d);
        check_eq("sb_cycle", cyc, mon_e.c);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(logic [2:0] a, logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = {11'd0, a}; wr_data = d;
    tick(1);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic reg_chk(string tag, logic [2:0] a, logic [31:0] exp);
    addr = {11'd0, a};
    #1;
    check_eq(tag, rd_data, exp);
  endtask

  // Program geometry, queue the expected writes, then issue start.
  task automatic start_fill(int x0, int y0, int w, int h, int col, int stall_rel,
                            int max_push, output int t, output int n);
    int cw, ch, c, pushed;
    wr_t e;
    reg_wr(REG_X0, 32'(x0));
    reg_wr(REG_Y0, 32'(y0));
    reg_wr(REG_W, 32'(w));
    reg_wr(REG_H, 32'(h));
    reg_wr(REG_COLOR, 32'(col));
    cw = (x0 >= HMAX) ? 0 : ((w < HMAX - x0) ? w : HMAX - x0);
    ch = (y0 >= VMAX) ? 0 : ((h < VMAX - y0) ? h : VMAX - y0);
    n = cw * ch;
    t = cyc;
    c = t + 2;
    pushed = 0;
    for (int r = 0; r < ch; r++) begin
      for (int k = 0; k < cw; k++) begin
        if (stall_rel != 0 && c == t + stall_rel) begin
          e.a = 20'd5; e.d = 32'd7; e.c = c;
          sb.push_back(e);
          c++;
        end
        if (pushed < max_push) begin
          e.a = 20'((y0 + r) * HMAX + x0 + k);
          e.d = 32'(col);
          e.c = c;
          sb.push_back(e);
          pushed++;
        end
        c++;
      end
    end
    reg_wr(REG_CTRL, 32'd1);
  endtask

  task automatic finish_fill(string tag, int exp_fall, int exp_cnt, int exp_stat);
    int k;
    k = 0;
    while (busy && k < 20000) begin
      tick(1);
      k++;
    end
    check_eq({tag, "_busy_fall_cycle"}, cyc, exp_fall);
    reg_chk({tag, "_status"}, REG_CTRL, exp_stat);
    reg_chk({tag, "_count"}, REG_CNT, exp_cnt);
  endtask

  int t, n;

  initial begin
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_fb_cs", {31'd0, fb_cs}, 32'd0);
    for (int i = 0; i < 8; i++) reg_chk("rst_reg", 3'(i), 32'd0);
    mon_en = 1'b1;

    // Basic 3x2 fill, no CPU traffic.
    start_fill(10, 20, 3, 2, 32'h1A5, 0, 100000, t, n);
    finish_fill("basic", t + 8, 6, 32'd2);
    reg_chk("basic_color_rb", REG_COLOR, 32'h1A5);

    // Same fill with a CPU write stealing cycle t+3.
    start_fill(10, 20, 3, 2, 32'h1A5, 3, 100000, t, n);
    tick(2);
    cpu_fb_cs = 1'b1; cpu_fb_wr = 1'b1; cpu_fb_addr = 20'd5; cpu_fb_wr_data = 32'd7;
    tick(1);
    cpu_fb_cs = 1'b0; cpu_fb_wr = 1'b0; cpu_fb_addr = 20'd0; cpu_fb_wr_data = 32'd0;
    finish_fill("stall", t + 9, 6, 32'd2);

    // Bottom-right clip to 10x5.
    start_fill(630, 475, 20, 20, 32'h0C3, 0, 100000, t, n);
    finish_fill("clip", t + 52, 50, 32'd2);

    // Empty fills: origin off-screen, then zero width.
    start_fill(700, 0, 5, 5, 32'h011, 0, 100000, t, n);
    finish_fill("empty_x", t + 2, 0, 32'd2);
    start_fill(0, 0, 0, 5, 32'h011, 0, 100000, t, n);
    finish_fill("empty_w", t + 2, 0, 32'd2);

    // Abort in the cycle of the 37th granted pixel; that pixel still lands.
    start_fill(0, 0, 100, 100, 32'h0AA, 0, 37, t, n);
    tick(37);
    reg_wr(REG_CTRL, 32'd2);
    finish_fill("abort", t + 39, 37, 32'd4);
    start_fill(5, 5, 4, 3, 32'h155, 0, 100000, t, n);
    finish_fill("after_abort", t + 14, 12, 32'd2);

    // Start and abort together from idle: no fill, aborted set, done kept.
    reg_wr(REG_CTRL, 32'd3);
    tick(2);
    check_eq("start_abort_busy", {31'd0, busy}, 32'd0);
    reg_chk("start_abort_status", REG_CTRL, 32'd6);
    reg_chk("start_abort_count", REG_CNT, 32'd12);

    // Restart and geometry write while running are ignored.
    start_fill(3, 4, 50, 2, 32'h0FF, 0, 100000, t, n);
    tick(5);
    reg_wr(REG_X0, 32'd123);
    reg_wr(REG_CTRL, 32'd1);
    reg_chk("midrun_status", REG_CTRL, 32'd1);
    finish_fill("midrun", t + 102, 100, 32'd2);
    reg_chk("midrun_x0_kept", REG_X0, 32'd3);

    // Reset in the middle of a fill.
    start_fill(0, 0, 10, 10, 32'h055, 0, 3, t, n);
    tick(3);
    reset = 1'b1;
    tick(1);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_fb_cs", {31'd0, fb_cs}, 32'd0);
    reset = 1'b0;
    tick(2);
    check_eq("reset_still_idle", {31'd0, busy}, 32'd0);
    reg_chk("reset_status", REG_CTRL, 32'd0);
    reg_chk("reset_count", REG_CNT, 32'd0);
    reg_chk("reset_x0", REG_X0, 32'd0);

    tick(2);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
